fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch sequencer in front of the combinational instruction memory.
//   Owns the PC and drives the memory address with an optional wait-state count.
//   Registers each returned word with its PC and hands it to decode over a
//   valid/ready handshake. Takes PC redirects (branch/jump) from execute.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset
//   MEM_LAT   0              extra wait cycles per fetch before inst is sampled (0..15)
//   LAT_W     4              width of wait-state counter
// PORTS
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   imem_addr       out  32  address to instruction memory (= pc)
//   imem_req        out  1   high while a fetch is in flight
//   imem_inst       in   32  instruction word returned by memory
//   fetch_valid     out  1   fetch_inst/fetch_pc hold a valid instruction
//   fetch_ready     in   1   decode accepts the word this cycle
//   fetch_inst      out  32  registered instruction
//   fetch_pc        out  32  byte address of fetch_inst
//   redirect_valid  in   1   load redirect_pc, flush fetch
//   redirect_pc     in   32  new PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//   - Reset (async): pc=RESET_PC, state=IDLE, cnt=0, imem_req=0, fetch_valid=0,
//     fetch_inst=0, fetch_pc=0. imem_addr=pc at all times.
//   - FSM: IDLE -> FETCH on first clk after reset release.
//     FETCH: imem_req=1; if MEM_LAT==0 and slot free, capture; else cnt<=MEM_LAT-1, -> WAIT
//            (MEM_LAT==0 and slot busy -> HOLD).
//     WAIT : imem_req=1; cnt decrements; at cnt==0 capture if slot free, else -> HOLD.
//     HOLD : imem_req=1; capture as soon as slot free, then -> FETCH.
//   - Slot free = !fetch_valid || fetch_ready. Capture: fetch_inst<=imem_inst,
//     fetch_pc<=pc, fetch_valid<=1, pc<=pc+4; state FETCH (new fetch starts next cycle).
//   - fetch_valid, fetch_inst, fetch_pc stable while fetch_valid && !fetch_ready.
//     A word not replaced by a capture clears fetch_valid after acceptance.
//   - Throughput with MEM_LAT=0: one word per cycle while fetch_ready=1.
//     With MEM_LAT=N: one word per N+1 cycles.
//   - Redirect (highest priority, any state except IDLE): pc<={redirect_pc[31:2],2'b00},
//     fetch_valid<=0, cnt<=0, in-flight fetch dropped, state<=FETCH.
//     Word accepted the same cycle (valid&&ready) counts as transferred. No capture that edge.
//   - Redirect during IDLE: pc is loaded, state -> FETCH.
//   - PC wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//   - Reset asserted mid-fetch: all state returns to reset values immediately.
//   - Latency MEM_LAT=0: redirect sampled at edge N -> imem_addr=target in cycle N+1,
//     fetch_valid=1 with that word after edge N+1.
// CONFIGURATION
//   FETCH_JUMP_PREDECODE_EN defined: at capture, if imem_inst[31:26] is 6'b000010 (j)
//     or 6'b000011 (jal), next pc = {pc_plus4[31:28], imem_inst[25:0], 2'b00}
//     instead of pc+4. The jump word is still delivered to decode. External redirect
//     still wins on the same edge.
//   Not defined: pc always advances by 4; jumps rely on redirect_valid.
// TESTING
//   1 Reset release, MEM_LAT=0, ready=1 -> words 0xAC000008 @pc0, 0xAC210004 @pc4,
//     0x20020002 @pc8, one per cycle, first valid 2 cycles after rst_n rises.
//   2 ready=0 for 3 cycles while valid @pc4 -> fetch_inst 0xAC210004 held, pc stays 8,
//     imem_req=1; on ready=1 next word @pc8 follows next cycle, none lost/duplicated.
//   3 redirect_valid with redirect_pc=32'h0000_000F while fetching @pc12 -> next fetch_pc=0xC,
//     no word from old stream delivered after redirect edge.
//   4 MEM_LAT=3 -> fetch_valid pulses every 4 cycles with ready=1; pcs 0,4,8 in order.
//   5 FETCH_JUMP_PREDECODE_EN, word 0x08000020 @pc20 -> next fetch_pc=0x80 without redirect;
//     macro undefined -> next fetch_pc=0x18.
//   6 redirect_pc=32'hFFFF_FFFC, two accepts -> fetch_pc 0xFFFFFFFC then 0x00000000;
//     rst_n low mid-WAIT -> fetch_valid=0, pc=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode handshake and redirect input.
// Decode handshake: a word transfers on a rising edge where fetch_valid && fetch_ready;
// while fetch_valid is high and fetch_ready low, fetch_valid/fetch_inst/fetch_pc hold.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_inst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_addr, imem_req, fetch_valid, fetch_inst, fetch_pc,
    input  imem_inst, fetch_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_req, fetch_valid, fetch_inst, fetch_pc,
    output imem_inst, fetch_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, waits MEM_LAT cycles per fetch, hands words to decode.
// Optional FETCH_JUMP_PREDECODE_EN: j/jal words steer the next PC at capture time.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_LAT  = 0,
  parameter int          LAT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  localparam logic [LAT_W-1:0] LAT_INIT = (MEM_LAT == 0) ? '0 : LAT_W'(MEM_LAT - 1);

  state_t           state, state_nx;
  logic [31:0]      pc, pc_plus4, next_pc;
  logic [LAT_W-1:0] cnt, cnt_nx;
  logic             capture, slot_free;
  logic             valid_q;
  logic [31:0]      inst_q, fpc_q;
  logic             unused_rpc;

  assign slot_free = !valid_q || bus.fetch_ready;
  assign pc_plus4  = pc + 32'd4;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic is_jump;
  assign is_jump = (bus.imem_inst[31:26] == 6'b000010) || (bus.imem_inst[31:26] == 6'b000011);
  assign next_pc = is_jump ? {pc_plus4[31:28], bus.imem_inst[25:0], 2'b00} : pc_plus4;
`else
  assign next_pc = pc_plus4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (MEM_LAT == 0) begin
          if (slot_free) capture  = 1'b1;
          else           state_nx = HOLD;
        end else begin
          cnt_nx   = LAT_INIT;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          if (slot_free) begin
            capture  = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = HOLD;
          end
        end else begin
          cnt_nx = cnt - LAT_W'(1);
        end
      end
      HOLD: begin
        if (slot_free) begin
          capture  = 1'b1;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A redirect abandons whatever fetch is in flight, including a due capture.
    if (bus.redirect_valid) begin
      state_nx = FETCH;
      cnt_nx   = '0;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      cnt     <= '0;
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      fpc_q   <= 32'd0;
    end else begin
      cnt <= cnt_nx;
      if (bus.redirect_valid) begin
        pc      <= {bus.redirect_pc[31:2], 2'b00};
        valid_q <= 1'b0;
      end else if (capture) begin
        inst_q  <= bus.imem_inst;
        fpc_q   <= pc;
        valid_q <= 1'b1;
        pc      <= next_pc;
      end else if (bus.fetch_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.imem_req    = (state != IDLE);
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_inst  = inst_q;
  assign bus.fetch_pc    = fpc_q;
  assign dbg_state       = state;
  assign unused_rpc      = ^bus.redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic
// checked against a stream-level model of which PC must be delivered next.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [1:0] dbg0, dbg3;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit_if b0();
  fetch_unit_if b3();

  fetch_unit #(.RESET_PC(32'h0), .MEM_LAT(0), .LAT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.master), .dbg_state(dbg0));
  fetch_unit #(.RESET_PC(32'h0), .MEM_LAT(3), .LAT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.master), .dbg_state(dbg3));

  // Instruction memory contents: fixed words at the directed addresses, hashed elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0:  return 32'hAC00_0008;
      32'h4:  return 32'hAC21_0004;
      32'h8:  return 32'h2002_0002;
      32'h14: return 32'h0800_0020;
      default: begin
        h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        return {1'b1, h[30:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] inst);
`ifdef FETCH_JUMP_PREDECODE_EN
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (inst[31:26] == 6'd2 || inst[31:26] == 6'd3) return {p4[31:28], inst[25:0], 2'b00};
`endif
    return p + 32'd4 + (32'd0 & inst);
  endfunction

  assign b0.imem_inst = mem_word(b0.imem_addr);
  assign b3.imem_inst = mem_word(b3.imem_addr);

  task automatic do_reset(input logic r0, input logic r3);
    @(negedge clk);
    rst_n = 1'b0;
    b0.fetch_ready = r0; b3.fetch_ready = r3;
    b0.redirect_valid = 1'b0; b3.redirect_valid = 1'b0;
    b0.redirect_pc = 32'd0; b3.redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    b0.fetch_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (b0.fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got %b want 0", b0.fetch_valid); end
    tests_run++; if (b0.fetch_inst !== 32'd0) begin tests_failed++; $display("FAIL rst_inst got %h want 0", b0.fetch_inst); end
    tests_run++; if (b0.fetch_pc !== 32'd0) begin tests_failed++; $display("FAIL rst_pc got %h want 0", b0.fetch_pc); end
    tests_run++; if (b0.imem_addr !== 32'd0) begin tests_failed++; $display("FAIL rst_addr got %h want 0", b0.imem_addr); end
    tests_run++; if (b0.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %b want 0", b0.imem_req); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (b0.fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL first_cycle_valid got %b want 0", b0.fetch_valid); end
    tests_run++; if (b0.imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_cycle_req got %b want 1", b0.imem_req); end
    @(negedge clk);
    tests_run++; if (b0.fetch_valid !== 1'b1 || b0.fetch_pc !== 32'h0 || b0.fetch_inst !== 32'hAC00_0008) begin
      tests_failed++; $display("FAIL first_word got v=%b pc=%h inst=%h want v=1 pc=0 inst=ac000008", b0.fetch_valid, b0.fetch_pc, b0.fetch_inst); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    tests_run++; if (b0.fetch_valid !== 1'b1 || b0.fetch_pc !== 32'h4 || b0.fetch_inst !== 32'hAC21_0004) begin
      tests_failed++; $display("FAIL stream_w1 got v=%b pc=%h inst=%h want v=1 pc=4 inst=ac210004", b0.fetch_valid, b0.fetch_pc, b0.fetch_inst); end
    @(negedge clk);
    tests_run++; if (b0.fetch_valid !== 1'b1 || b0.fetch_pc !== 32'h8 || b0.fetch_inst !== 32'h2002_0002) begin
      tests_failed++; $display("FAIL stream_w2 got v=%b pc=%h inst=%h want v=1 pc=8 inst=20020002", b0.fetch_valid, b0.fetch_pc, b0.fetch_inst); end
  endtask

  task automatic test_stall();
    int n;
    do_reset(1'b1, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(b0.fetch_valid === 1'b1 && b0.fetch_pc === 32'h4) && n < 20);
    tests_run++; if (n >= 20) begin tests_failed++; $display("FAIL stall_reach got timeout want word at pc 4"); end
    b0.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (b0.fetch_valid !== 1'b1 || b0.fetch_pc !== 32'h4 || b0.fetch_inst !== 32'hAC21_0004) begin
        tests_failed++; $display("FAIL stall_hold%0d got v=%b pc=%h inst=%h want v=1 pc=4 inst=ac210004", i, b0.fetch_valid, b0.fetch_pc, b0.fetch_inst); end
      tests_run++; if (b0.imem_addr !== 32'h8 || b0.imem_req !== 1'b1) begin
        tests_failed++; $display("FAIL stall_addr%0d got addr=%h req=%b want addr=8 req=1", i, b0.imem_addr, b0.imem_req); end
    end
    b0.fetch_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (b0.fetch_valid !== 1'b1 || b0.fetch_pc !== 32'h8 || b0.fetch_inst !== 32'h2002_0002) begin
      tests_failed++; $display("FAIL stall_resume got v=%b pc=%h inst=%h want v=1 pc=8 inst=20020002", b0.fetch_valid, b0.fetch_pc, b0.fetch_inst); end
    @(negedge clk);
    tests_run++; if (b0.fetch_valid !== 1'b1 || b0.fetch_pc !== 32'hC) begin
      tests_failed++; $display("FAIL stall_next got v=%b pc=%h want v=1 pc=c", b0.fetch_valid, b0.fetch_pc); end
  endtask

  // Redirect at negedge, then check the flushed cycle and the first two words of the new stream.
  task automatic redirect_check(input string name, input logic [31:0] target);
    logic [31:0] p;
    p = {target[31:2], 2'b00};
    b0.redirect_valid = 1'b1; b0.redirect_pc = target;
    @(negedge clk);
    b0.redirect_valid = 1'b0;
    tests_run++; if (b0.fetch_valid !== 1'b0 || b0.imem_addr !== p) begin
      tests_failed++; $display("FAIL %s_flush got v=%b addr=%h want v=0 addr=%h", name, b0.fetch_valid, b0.imem_addr, p); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++; if (b0.fetch_valid !== 1'b1 || b0.fetch_pc !== p || b0.fetch_inst !== mem_word(p)) begin
        tests_failed++; $display("FAIL %s_w%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", name, i, b0.fetch_valid, b0.fetch_pc, b0.fetch_inst, p, mem_word(p)); end
      p = model_next(p, mem_word(p));
    end
  endtask

  task automatic test_redirect();
    int n;
    do_reset(1'b1, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (b0.imem_addr !== 32'hC && n < 20);
    tests_run++; if (n >= 20) begin tests_failed++; $display("FAIL redir_reach got timeout want addr c"); end
    redirect_check("redir", 32'h0000_000F);
  endtask

  task automatic test_jump();
    logic [31:0] want;
`ifdef FETCH_JUMP_PREDECODE_EN
    want = 32'h80;
`else
    want = 32'h18;
`endif
    @(negedge clk);
    b0.fetch_ready = 1'b1;
    redirect_check("jump", 32'h14);
    tests_run++; if (b0.fetch_pc !== 32'h14 + 32'd0 && b0.fetch_pc !== want) begin
      tests_failed++; $display("FAIL jump_seq got pc=%h want %h", b0.fetch_pc, want); end
    if (b0.fetch_pc === 32'h14) @(negedge clk);
    tests_run++; if (b0.fetch_pc !== want) begin tests_failed++; $display("FAIL jump_target got pc=%h want %h", b0.fetch_pc, want); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect_check("wrap", 32'hFFFF_FFFC);
    tests_run++; if (b0.fetch_pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_zero got pc=%h want 0", b0.fetch_pc); end
  endtask

  task automatic test_latency();
    logic exp_v;
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp_v = (k >= 5) && ((k - 5) % 4 == 0);
      tests_run++; if (b3.fetch_valid !== exp_v) begin
        tests_failed++; $display("FAIL lat_valid cycle %0d got %b want %b", k, b3.fetch_valid, exp_v); end
      if (exp_v) begin
        tests_run++; if (b3.fetch_pc !== 32'(4 * ((k - 5) / 4))) begin
          tests_failed++; $display("FAIL lat_pc cycle %0d got %h want %h", k, b3.fetch_pc, 32'(4 * ((k - 5) / 4))); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(1'b1, 1'b0);
    repeat (7) @(negedge clk);
    tests_run++; if (b3.fetch_valid !== 1'b1 || b3.fetch_pc !== 32'h0 || b3.imem_addr !== 32'h4) begin
      tests_failed++; $display("FAIL midwait_pre got v=%b pc=%h addr=%h want v=1 pc=0 addr=4", b3.fetch_valid, b3.fetch_pc, b3.imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (b3.fetch_valid !== 1'b0 || b3.imem_addr !== 32'h0 || b3.imem_req !== 1'b0 || b3.fetch_inst !== 32'h0) begin
      tests_failed++; $display("FAIL midwait_rst got v=%b addr=%h req=%b inst=%h want 0/0/0/0", b3.fetch_valid, b3.imem_addr, b3.imem_req, b3.fetch_inst); end
  endtask

  task automatic test_random(input bit which, input int cycles);
    logic v, r, rd;
    logic [31:0] p, i, tgt;
    int accepted;
    accepted = 0;
    do_reset(1'b1, 1'b1);
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      v = which ? b3.fetch_valid : b0.fetch_valid;
      p = which ? b3.fetch_pc : b0.fetch_pc;
      i = which ? b3.fetch_inst : b0.fetch_inst;
      if (v) begin
        tests_run++; if (p !== exp_q[0] || i !== mem_word(exp_q[0])) begin
          tests_failed++; $display("FAIL rand%0d_word cycle %0d got pc=%h inst=%h want pc=%h inst=%h", which, c, p, i, exp_q[0], mem_word(exp_q[0])); end
      end
      r   = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      tgt = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if (which) begin b3.fetch_ready = r; b3.redirect_valid = rd; b3.redirect_pc = tgt; end
      else       begin b0.fetch_ready = r; b0.redirect_valid = rd; b0.redirect_pc = tgt; end
      if (v && r) begin
        accepted++;
        exp_q.push_back(model_next(exp_q[0], mem_word(exp_q[0])));
        void'(exp_q.pop_front());
      end
      if (rd) begin
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
      end
    end
    @(negedge clk);
    b0.redirect_valid = 1'b0; b3.redirect_valid = 1'b0;
    tests_run++; if (!(accepted > cycles / 20)) begin
      tests_failed++; $display("FAIL rand%0d_progress got %0d accepts want > %0d", which, accepted, cycles / 20); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.fetch_ready = 1'b1; b3.fetch_ready = 1'b1;
    b0.redirect_valid = 1'b0; b3.redirect_valid = 1'b0;
    b0.redirect_pc = 32'd0; b3.redirect_pc = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_jump();
    test_wrap();
    test_latency();
    test_reset_mid_wait();
    test_random(1'b0, 1500);
    test_random(1'b1, 1500);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
